// File: rtl/palindrome_generator_if.sv
// Output stream of the palindrome generator: word, valid and the consumer's ready.
interface palindrome_generator_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/palindrome_generator.sv
// Streams every WIDTH-bit binary palindrome between two upper halves, ascending,
// by mirroring a HALF-bit counter onto the low half of the word.
module palindrome_generator #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned HALF = WIDTH / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [HALF-1:0]        start_half,
  input  logic [HALF-1:0]        end_half,
  input  logic                   abort,
  palindrome_generator_if.master dout,
  output logic                   busy,
  output logic                   done,
  output logic [HALF:0]          count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [HALF-1:0] h_q, h_d;
  logic [HALF-1:0] lim_q, lim_d;
  logic [HALF:0]   count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      h_q     <= '0;
      lim_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      lim_q   <= lim_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    lim_d   = lim_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          h_d     = start_half;
          lim_d   = end_half;
          count_d = '0;
          state_d = (start_half <= end_half) ? StRun : StDone;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (dout.data_ready) begin
          count_d = count_q + 1'b1;
          // Compare before incrementing so an all-ones limit never wraps.
          if (h_q == lim_q) begin
            state_d = StDone;
          end else begin
            h_d = h_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dout.data_valid = (state_q == StRun);
    busy            = (state_q == StRun) || (state_q == StDone);
    done            = (state_q == StDone);
    count           = count_q;
    dout.data_out[WIDTH-1:HALF] = h_q;
    for (int i = 0; i < HALF; i++) begin
      dout.data_out[i] = h_q[HALF-1-i];
    end
  end

endmodule

// File: tb/tb_palindrome_generator.sv
// Directed and randomized bench for palindrome_generator (WIDTH=8) against a
// queue-based model of the expected word sequence.
module tb_palindrome_generator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] start_half;
  logic [3:0] end_half;
  logic       abort;
  logic       busy;
  logic       done;
  logic [4:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  palindrome_generator_if #(.WIDTH(8)) dif ();

  palindrome_generator #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_half (start_half),
    .end_half   (end_half),
    .abort      (abort),
    .dout       (dif),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upper half v followed by v with its four bits read in reverse order.
  function automatic logic [7:0] pal(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return 8'(v * 16 + r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 ready always, 1 random ready, 2 ready low for 3 cycles then high.
  // abort_after >= 0 aborts once that many words have transferred.
  task automatic run(input int s, input int e, input int mode, input int abort_after);
    logic [7:0] q[$];
    int xfers = 0;
    int cyc = 0;
    logic rdy;
    for (int v = s; v <= e; v++) q.push_back(pal(v));
    start = 1'b1;
    start_half = 4'(s);
    end_half = 4'(e);
    step();
    start = 1'b0;
    while (q.size() > 0) begin
      check("run_valid", dif.data_valid, 1);
      check("run_data", dif.data_out, q[0]);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_count", count, xfers);
      if (abort_after >= 0 && xfers == abort_after) begin
        abort = 1'b1;
        dif.data_ready = 1'($urandom % 2);
        step();
        abort = 1'b0;
        dif.data_ready = 1'b0;
        check("abort_valid", dif.data_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_count", count, xfers);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        2:       rdy = (cyc >= 3);
        default: rdy = 1'($urandom % 2);
      endcase
      // A start during RUN must not disturb the run.
      if (cyc == 2) begin
        start = 1'b1;
        start_half = 4'(~s);
        end_half = 4'(~s);
      end
      dif.data_ready = rdy;
      step();
      start = 1'b0;
      cyc++;
      if (rdy) begin
        void'(q.pop_front());
        xfers++;
      end
      if (cyc > 300) begin
        n_fail++;
        $display("FAIL timeout: run %0h..%0h still pending after %0d cycles", s, e, cyc);
        return;
      end
    end
    dif.data_ready = 1'b0;
    check("done_pulse", done, 1);
    check("done_valid", dif.data_valid, 0);
    check("done_busy", busy, 1);
    check("done_count", count, xfers);
    step();
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", dif.data_valid, 0);
    check("idle_count", count, xfers);
  endtask

  initial begin
    int a;
    int b;
    rst = 1'b1;
    start = 1'b0;
    start_half = '0;
    end_half = '0;
    abort = 1'b0;
    dif.data_ready = 1'b0;
    #2;
    check("rst_valid", dif.data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_data", dif.data_out, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    run(0, 3, 0, -1);
    run(0, 15, 0, -1);
    run(10, 10, 2, -1);
    run(5, 2, 0, -1);
    run(0, 15, 0, 3);
    run(1, 1, 0, -1);
    for (int k = 0; k < 6; k++) begin
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      run(a, b, 1, -1);
    end
    run(3, 14, 1, 4);

    // Reset in the middle of a run.
    start = 1'b1;
    start_half = 4'h0;
    end_half = 4'hF;
    dif.data_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", dif.data_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_data", dif.data_out, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_done", done, 0);
      check("post_rst_valid", dif.data_valid, 0);
    end

    // Reset while in DONE.
    dif.data_ready = 1'b0;
    start = 1'b1;
    start_half = 4'h5;
    end_half = 4'h2;
    step();
    start = 1'b0;
    check("empty_done", done, 1);
    #1 rst = 1'b1;
    #1;
    check("done_rst_done", done, 0);
    check("done_rst_busy", busy, 0);
    rst = 1'b0;
    step();
    check("done_rst_after", done, 0);
    check("done_rst_after_busy", busy, 0);

    run(0, 15, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
